// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC NCO front end: FSM states, angle format,
// dither LFSR constants and the rotator gain constant K.
package cordic_pkg;

   typedef enum logic [1:0] {
      NCO_IDLE,
      NCO_ISSUE,
      NCO_WAIT,
      NCO_HOLD
   } nco_state_e;

   // 2^ANGLE_WIDTH = 2*pi; the top QUADRANT_MSBS bits of an angle select the quadrant.
   localparam int unsigned QUADRANT_MSBS = 2;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // K = prod_{i<iterations} 1/sqrt(1+2^-2i), rounded to point_width-2 fraction bits.
   // K^2 is formed exactly in Q62 integer arithmetic, then an integer square root gives Q31.
   function automatic logic [63:0] cordic_gain_q(input int unsigned point_width,
                                                 input int unsigned iterations);
      logic [63:0] k2;
      logic [63:0] rem;
      logic [63:0] root;
      logic [63:0] bitv;
      int unsigned frac;
      k2 = 64'h4000_0000_0000_0000;
      for (int unsigned i = 0; i < iterations; i++) begin
         if (i < 32) begin
            k2 = k2 - k2 / ((64'd1 << (2 * i)) + 64'd1);
         end
      end
      rem  = k2;
      root = '0;
      bitv = 64'd1 << 62;
      for (int unsigned b = 0; b < 32; b++) begin
         if (rem >= root + bitv) begin
            rem  = rem - (root + bitv);
            root = (root >> 1) + bitv;
         end else begin
            root = root >> 1;
         end
         bitv = bitv >> 2;
      end
      frac = point_width - 2;
      if (frac >= 31) begin
         return root << (frac - 31);
      end
      return (root + (64'd1 << (30 - frac))) >> (31 - frac);
   endfunction

endpackage

// File: rtl/cordic_phase_acc.sv
// Phase accumulator, increment register and clear-pending flag for the NCO.
// Optional macro NCO_DITHER_EN adds LFSR dither below the truncation point of phase_z only.
module cordic_phase_acc #(
   parameter int unsigned ACC_WIDTH   = 32,
   parameter int unsigned ANGLE_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ACC_WIDTH-1:0]   freq_word,
   input  logic                   freq_load,
   input  logic [ANGLE_WIDTH-1:0] phase_offset,
   input  logic                   phase_clear,
   input  logic                   advance,
   output logic [ANGLE_WIDTH-1:0] phase_z
);
   import cordic_pkg::*;

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] inc_q, inc_d;
   logic                 clr_pend_q, clr_pend_d;
   logic                 clr_now;
   logic [ACC_WIDTH-1:0] acc_base;
   logic [ACC_WIDTH-1:0] acc_for_z;

   if (ACC_WIDTH < ANGLE_WIDTH) begin : g_bad_acc
      $error("ACC_WIDTH must be >= ANGLE_WIDTH");
   end
   if (ANGLE_WIDTH < QUADRANT_MSBS) begin : g_bad_angle
      $error("ANGLE_WIDTH too small for the angle format");
   end

   // A clear seen on the launch edge itself is consumed by that launch.
   always_comb begin
      clr_now    = clr_pend_q | phase_clear;
      acc_base   = clr_now ? '0 : acc_q;
      inc_d      = freq_load ? freq_word : inc_q;
      acc_d      = acc_q;
      clr_pend_d = clr_now;
      if (advance) begin
         acc_d      = acc_base + inc_q;
         clr_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         inc_q      <= '0;
         clr_pend_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         inc_q      <= inc_d;
         clr_pend_q <= clr_pend_d;
      end
   end

`ifdef NCO_DITHER_EN
   localparam int unsigned DW = ((ACC_WIDTH - ANGLE_WIDTH) < 16) ? (ACC_WIDTH - ANGLE_WIDTH) : 16;

   logic [15:0] lfsr_q, lfsr_d;

   if (ACC_WIDTH <= ANGLE_WIDTH) begin : g_bad_dither
      $error("dither needs ACC_WIDTH > ANGLE_WIDTH");
   end

   always_comb begin
      lfsr_d    = advance ? {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
      acc_for_z = acc_base + ACC_WIDTH'(lfsr_q[DW-1:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   always_comb begin
      acc_for_z = acc_base;
   end
`endif

   always_comb begin
      phase_z = acc_for_z[ACC_WIDTH-1 -: ANGLE_WIDTH] + phase_offset;
   end

endmodule

// File: rtl/cordic_nco_driver.sv
// NCO front end for the iterative CORDIC rotator: launches one rotation per sample and
// returns cos/sin on a valid/ready port. Optional macro NCO_DITHER_EN enables phase dither.
module cordic_nco_driver #(
   parameter int unsigned POINT_WIDTH = 16,
   parameter int unsigned ANGLE_WIDTH = 16,
   parameter int unsigned ACC_WIDTH   = 32,
   parameter int unsigned ITERATIONS  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [ACC_WIDTH-1:0]   freq_word,
   input  logic                   freq_load,
   input  logic [ANGLE_WIDTH-1:0] phase_offset,
   input  logic                   phase_clear,
   output logic                   cordic_start,
   output logic [POINT_WIDTH-1:0] cordic_x,
   output logic [POINT_WIDTH-1:0] cordic_y,
   output logic [ANGLE_WIDTH-1:0] cordic_z,
   input  logic                   cordic_done,
   input  logic [POINT_WIDTH-1:0] cordic_x_res,
   input  logic [POINT_WIDTH-1:0] cordic_y_res,
   output logic [POINT_WIDTH-1:0] cos_out,
   output logic [POINT_WIDTH-1:0] sin_out,
   output logic                   sample_valid,
   input  logic                   sample_ready,
   output logic                   busy
);
   import cordic_pkg::*;

   localparam logic [POINT_WIDTH-1:0] K_Q = POINT_WIDTH'(cordic_gain_q(POINT_WIDTH, ITERATIONS));

   nco_state_e             state_q, state_d;
   logic                   start_q, start_d;
   logic [POINT_WIDTH-1:0] x_q, x_d;
   logic [POINT_WIDTH-1:0] y_q, y_d;
   logic [ANGLE_WIDTH-1:0] z_q, z_d;
   logic [POINT_WIDTH-1:0] cos_q, cos_d;
   logic [POINT_WIDTH-1:0] sin_q, sin_d;
   logic                   valid_q, valid_d;
   logic                   busy_q, busy_d;
   logic                   advance;
   logic [ANGLE_WIDTH-1:0] phase_z;

   cordic_phase_acc #(
      .ACC_WIDTH   (ACC_WIDTH),
      .ANGLE_WIDTH (ANGLE_WIDTH)
   ) u_phase_acc (
      .clk          (clk),
      .rst_n        (rst_n),
      .freq_word    (freq_word),
      .freq_load    (freq_load),
      .phase_offset (phase_offset),
      .phase_clear  (phase_clear),
      .advance      (advance),
      .phase_z      (phase_z)
   );

   // Rotator inputs are loaded on the edge entering ISSUE, so they are valid while start is high.
   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      cos_d   = cos_q;
      sin_d   = sin_q;
      valid_d = valid_q;
      advance = 1'b0;
      unique case (state_q)
         NCO_IDLE: begin
            if (enable) advance = 1'b1;
         end
         NCO_ISSUE: begin
            state_d = NCO_WAIT;
         end
         NCO_WAIT: begin
            if (cordic_done) begin
               cos_d   = cordic_x_res;
               sin_d   = cordic_y_res;
               valid_d = 1'b1;
               state_d = NCO_HOLD;
            end
         end
         NCO_HOLD: begin
            if (valid_q && sample_ready) begin
               valid_d = 1'b0;
               if (enable) advance = 1'b1;
               else        state_d = NCO_IDLE;
            end
         end
         default: state_d = NCO_IDLE;
      endcase
      if (advance) begin
         state_d = NCO_ISSUE;
         start_d = 1'b1;
         x_d     = K_Q;
         y_d     = '0;
         z_d     = phase_z;
      end
      busy_d = (state_d != NCO_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= NCO_IDLE;
         start_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         cos_q   <= '0;
         sin_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign cordic_start = start_q;
   assign cordic_x     = x_q;
   assign cordic_y     = y_q;
   assign cordic_z     = z_q;
   assign cos_out      = cos_q;
   assign sin_out      = sin_q;
   assign sample_valid = valid_q;
   assign busy         = busy_q;

endmodule
